// File: rtl/mem_port_arbiter.sv
// Two-slot memory request arbiter sharing one single-ported data SRAM.
// Optional same-word merging of paired requests: define SAME_WORD_MERGE_EN.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req1_valid,
    input  logic [3:0]  req1_wen,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic        req2_valid,
    input  logic [3:0]  req2_wen,
    input  logic [31:0] req2_addr,
    input  logic [31:0] req2_wdata,
    input  logic        kill2,
    input  logic        flush,
    input  logic        stall_i,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic [31:0] mem_rdata1,
    output logic [31:0] mem_rdata2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        RETURN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hold1_q, hold1_d;
    logic        hold_vld_q, hold_vld_d;

    logic        req2_eff;
    logic        merge;
    logic [31:0] merged_wdata;
    logic        en_c;
    logic [3:0]  wen_c;
    logic        stallreq_c;

    assign req2_eff = req2_valid & ~kill2;

    always_comb begin
        merge        = 1'b0;
        merged_wdata = req1_wdata;
`ifdef SAME_WORD_MERGE_EN
        if (req1_valid && req2_eff && (req1_addr[31:2] == req2_addr[31:2])) begin
            if ((req1_wen == '0) && (req2_wen == '0))
                merge = 1'b1;
            else if ((req1_wen != '0) && (req2_wen != '0) && ((req1_wen & req2_wen) == '0))
                merge = 1'b1;
        end
        for (int unsigned b = 0; b < 4; b++) begin
            if (req2_wen[b])
                merged_wdata[8*b +: 8] = req2_wdata[8*b +: 8];
        end
`endif
    end

    always_comb begin
        state_d         = state_q;
        hold1_d         = hold1_q;
        hold_vld_d      = hold_vld_q;
        en_c            = 1'b0;
        wen_c           = '0;
        stallreq_c      = 1'b0;
        data_sram_addr  = req1_addr;
        data_sram_wdata = req1_wdata;

        if (flush) begin
            state_d    = IDLE;
            hold_vld_d = 1'b0;
        end else begin
            case (state_q)
                SECOND: begin
                    data_sram_addr  = req2_addr;
                    data_sram_wdata = req2_wdata;
                    en_c            = req2_eff;
                    wen_c           = req2_eff ? req2_wen : '0;
                    // Only the first SECOND cycle sees slot-1 read data on rdata.
                    if (!hold_vld_q) begin
                        hold1_d    = data_sram_rdata;
                        hold_vld_d = 1'b1;
                    end
                    if (!stall_i)
                        state_d = RETURN;
                end
                default: begin
                    // A stalled RETURN issues nothing so the SRAM keeps presenting slot-2 data.
                    if (!((state_q == RETURN) && stall_i)) begin
                        hold_vld_d = 1'b0;
                        state_d    = IDLE;
                        if (req1_valid) begin
                            en_c            = 1'b1;
                            wen_c           = merge ? (req1_wen | req2_wen) : req1_wen;
                            data_sram_wdata = merged_wdata;
                            if (req2_eff && !merge) begin
                                stallreq_c = 1'b1;
                                state_d    = SECOND;
                            end
                        end else if (req2_eff) begin
                            en_c            = 1'b1;
                            wen_c           = req2_wen;
                            data_sram_addr  = req2_addr;
                            data_sram_wdata = req2_wdata;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold1_q    <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold1_q    <= hold1_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign data_sram_en  = en_c & rst;
    assign data_sram_wen = rst ? wen_c : '0;
    assign stallreq      = stallreq_c & rst;
    assign mem_rdata1    = (state_q == RETURN) ? hold1_q : data_sram_rdata;
    assign mem_rdata2    = data_sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random pairs
// checked against a word-array memory model updated in program order.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1_valid, req2_valid;
    logic [3:0]  req1_wen, req2_wen;
    logic [31:0] req1_addr, req1_wdata, req2_addr, req2_wdata;
    logic        kill2, flush, stall_i;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] sram_rdata;
    logic        stallreq;
    logic [31:0] mem_rdata1, mem_rdata2;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem  [0:1023];
    logic [31:0] sram_mem [0:1023];
    logic [31:0] obs1, obs2;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req1_valid      (req1_valid),
        .req1_wen        (req1_wen),
        .req1_addr       (req1_addr),
        .req1_wdata      (req1_wdata),
        .req2_valid      (req2_valid),
        .req2_wen        (req2_wen),
        .req2_addr       (req2_addr),
        .req2_wdata      (req2_wdata),
        .kill2           (kill2),
        .flush           (flush),
        .stall_i         (stall_i),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (sram_rdata),
        .stallreq        (stallreq),
        .mem_rdata1      (mem_rdata1),
        .mem_rdata2      (mem_rdata2)
    );

    function automatic logic [31:0] init_word(input int unsigned k);
        if (k == 32'h40) return 32'hAAAA5555;
        if (k == 32'h80) return 32'h12345678;
        return (k * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // SRAM: read-first, 1-cycle latency, output held while not enabled.
    initial begin : sram_model
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) sram_mem[i] = init_word(i);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (data_sram_en) begin
                w = sram_mem[data_sram_addr[11:2]];
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b]) w[8*b +: 8] = data_sram_wdata[8*b +: 8];
                sram_mem[data_sram_addr[11:2]] <= w;
                sram_rdata <= sram_mem[data_sram_addr[11:2]];
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic ref_store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic idle_inputs();
        req1_valid = 1'b0; req2_valid = 1'b0;
        req1_wen = '0; req2_wen = '0;
        kill2 = 1'b0; flush = 1'b0; stall_i = 1'b0;
    endtask

    // Drives one request pair and checks port activity and returned data.
    task automatic do_pair(input logic v1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic v2, input logic [3:0] w2, input logic [31:0] a2, input logic [31:0] d2,
                           input logic k2);
        logic        e2, mrg, dual, xen, xst;
        logic [3:0]  xwen;
        logic [31:0] xaddr, xwd, x1, x2;
        e2  = v2 & ~k2;
        mrg = 1'b0;
`ifdef SAME_WORD_MERGE_EN
        if (v1 && e2 && (a1[31:2] == a2[31:2]) &&
            (((w1 == 4'h0) && (w2 == 4'h0)) || ((w1 != 4'h0) && (w2 != 4'h0) && ((w1 & w2) == 4'h0))))
            mrg = 1'b1;
`endif
        dual = v1 && e2 && !mrg;

        x1 = ref_mem[a1[11:2]];
        if (v1) ref_store(a1, w1, d1);
        x2 = ref_mem[a2[11:2]];
        if (e2) ref_store(a2, w2, d2);

        xen = 1'b0; xst = 1'b0; xwen = 4'h0; xaddr = a1; xwd = d1;
        if (v1) begin
            xen = 1'b1; xst = dual;
            xwen = mrg ? (w1 | w2) : w1;
            if (mrg)
                for (int b = 0; b < 4; b++) if (w2[b]) xwd[8*b +: 8] = d2[8*b +: 8];
        end else if (e2) begin
            xen = 1'b1; xwen = w2; xaddr = a2; xwd = d2;
        end

        @(negedge clk);
        req1_valid = v1; req1_wen = w1; req1_addr = a1; req1_wdata = d1;
        req2_valid = v2; req2_wen = w2; req2_addr = a2; req2_wdata = d2;
        kill2 = k2;
        #1;
        checks++;
        if (data_sram_en !== xen || data_sram_wen !== xwen || stallreq !== xst) begin
            errors++;
            $display("FAIL issue1 en/wen/stallreq got %b/%h/%b exp %b/%h/%b", data_sram_en, data_sram_wen, stallreq, xen, xwen, xst);
        end
        if (xen) begin
            checks++;
            if (data_sram_addr !== xaddr || (xwen != 4'h0 && data_sram_wdata !== xwd)) begin
                errors++;
                $display("FAIL issue1 addr/wdata got %h/%h exp %h/%h", data_sram_addr, data_sram_wdata, xaddr, xwd);
            end
        end
        if (dual) begin
            @(negedge clk);
            #1;
            checks++;
            if (data_sram_en !== 1'b1 || data_sram_addr !== a2 || data_sram_wen !== w2 || stallreq !== 1'b0 ||
                (w2 != 4'h0 && data_sram_wdata !== d2)) begin
                errors++;
                $display("FAIL issue2 en/addr/wen/stallreq got %b/%h/%h/%b exp 1/%h/%h/0", data_sram_en, data_sram_addr, data_sram_wen, stallreq, a2, w2);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        obs1 = mem_rdata1;
        obs2 = mem_rdata2;
        if ((v1 || dual) && w1 == 4'h0) begin
            checks++;
            if (mem_rdata1 !== x1) begin
                errors++;
                $display("FAIL rdata1 got %h exp %h", mem_rdata1, x1);
            end
        end
        if ((dual || mrg || (!v1 && e2)) && w2 == 4'h0) begin
            checks++;
            if (mem_rdata2 !== x2) begin
                errors++;
                $display("FAIL rdata2 got %h exp %h", mem_rdata2, x2);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        req1_valid = 1'b1; req1_wen = 4'hF; req1_addr = 32'h100; req1_wdata = 32'h1;
        req2_valid = 1'b1; req2_wen = 4'h0; req2_addr = 32'h200; req2_wdata = 32'h2;
        #2;
        checks++;
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs en/wen/stallreq got %b/%h/%b exp 0/0/0", data_sram_en, data_sram_wen, stallreq);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (data_sram_en !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset clocked en/stallreq got %b/%b exp 0/0", data_sram_en, stallreq);
        end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_load();
        do_pair(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (obs1 !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL single_load rdata1 got %h exp aaaa5555", obs1);
        end
    endtask

    task automatic test_dual_load();
        do_pair(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0);
        checks++;
        if (obs1 !== 32'hAAAA5555 || obs2 !== 32'h12345678) begin
            errors++;
            $display("FAIL dual_load rdata1/2 got %h/%h exp aaaa5555/12345678", obs1, obs2);
        end
    endtask

    task automatic test_store_load();
        do_pair(1'b1, 4'hF, 32'h300, 32'hDEADBEEF, 1'b1, 4'h0, 32'h300, 32'h0, 1'b0);
        checks++;
        if (obs2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_load rdata2 got %h exp deadbeef", obs2);
        end
    endtask

    task automatic test_stall_flush();
        int cnt;
        @(negedge clk);
        req1_valid = 1'b1; req1_wen = 4'h0; req1_addr = 32'h100; req1_wdata = '0;
        req2_valid = 1'b1; req2_wen = 4'h0; req2_addr = 32'h200; req2_wdata = '0;
        #1;
        checks++;
        if (stallreq !== 1'b1 || data_sram_addr !== 32'h100) begin
            errors++;
            $display("FAIL stall_first stallreq/addr got %b/%h exp 1/00000100", stallreq, data_sram_addr);
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stall_i = (i < 3);
            #1;
            if (data_sram_en === 1'b1 && data_sram_addr === 32'h200 && stallreq === 1'b0) cnt++;
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL stall_reissue count got %0d exp 4", cnt);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (mem_rdata1 !== 32'hAAAA5555 || mem_rdata2 !== 32'h12345678) begin
            errors++;
            $display("FAIL stall_return rdata1/2 got %h/%h exp aaaa5555/12345678", mem_rdata1, mem_rdata2);
        end
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = 32'h100;
        req2_valid = 1'b1; req2_addr = 32'h200;
        @(negedge clk);
        flush = 1'b1;
        stall_i = 1'b1;
        #1;
        checks++;
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0) begin
            errors++;
            $display("FAIL flush_second en/wen got %b/%h exp 0/0", data_sram_en, data_sram_wen);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stallreq !== 1'b0 || data_sram_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle stallreq/en got %b/%b exp 0/0", stallreq, data_sram_en);
        end
        do_pair(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0);
        checks++;
        if (obs1 !== 32'h12345678 || obs2 !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL flush_recapture rdata1/2 got %h/%h exp 12345678/aaaa5555", obs1, obs2);
        end
    endtask

    task automatic test_reset_mid_second();
        @(negedge clk);
        req1_valid = 1'b1; req1_wen = 4'h0; req1_addr = 32'h100;
        req2_valid = 1'b1; req2_wen = 4'h0; req2_addr = 32'h200;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (data_sram_en !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_second en/stallreq got %b/%b exp 0/0", data_sram_en, stallreq);
        end
        @(negedge clk);
        checks++;
        if (data_sram_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_held en got %b exp 0", data_sram_en);
        end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_kill2();
        do_pair(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b1);
        checks++;
        if (obs1 !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL kill2 rdata1 got %h exp aaaa5555", obs1);
        end
    endtask

    task automatic test_merge();
        do_pair(1'b1, 4'b0001, 32'h400, 32'h000000A1, 1'b1, 4'b0010, 32'h401, 32'h0000B200, 1'b0);
        do_pair(1'b1, 4'h0, 32'h400, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (obs1[15:0] !== 16'hB2A1) begin
            errors++;
            $display("FAIL merge_readback got %h exp b2a1", obs1[15:0]);
        end
        do_pair(1'b1, 4'h0, 32'h400, 32'h0, 1'b1, 4'h0, 32'h402, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic        v1, v2, k2;
        logic [3:0]  w1, w2;
        logic [31:0] a1, a2, d1, d2;
        for (int n = 0; n < 80; n++) begin
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 3) != 0);
            k2 = ($urandom_range(0, 5) == 0);
            a1 = 32'h500 | ($urandom_range(0, 7) << 2);
            w1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            w2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 0) begin
                a2 = {a1[31:2], 2'($urandom_range(0, 3))};
                if ($urandom_range(0, 1) == 0) w2 = ~w1 & 4'($urandom_range(1, 15));
            end else begin
                a2 = 32'h500 | ($urandom_range(0, 7) << 2);
            end
            d1 = $urandom;
            d2 = $urandom;
            do_pair(v1, w1, a1, d1, v2, w2, a2, d2, k2);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        req1_addr = '0; req1_wdata = '0; req2_addr = '0; req2_wdata = '0;
        obs1 = '0; obs2 = '0;
        test_reset();
        test_single_load();
        test_dual_load();
        test_store_load();
        test_stall_flush();
        test_reset_mid_second();
        test_kill2();
        test_merge();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset (0 = reset).
REQ-002 The block SHALL have the following slot-1 request ports: req1_valid in 1; req1_wen in 4 (byte write enables, 0 = load); req1_addr in 32; req1_wdata in 32.
REQ-003 The block SHALL have slot-2 request ports with the same names, directions and widths, prefixed req2_.
REQ-004 The block SHALL have the following control ports: kill2 in 1 (slot-2 access suppressed by slot-1 exception); flush in 1; stall_i in 1 (MEM stage held by ctrl).
REQ-005 The block SHALL have the following SRAM ports: data_sram_en out 1; data_sram_wen out 4; data_sram_addr out 32; data_sram_wdata out 32; data_sram_rdata in 32 (1-cycle read latency).
REQ-006 The block SHALL have the following outputs: stallreq out 1 (to ctrl; holds the EX pair); mem_rdata1 out 32; mem_rdata2 out 32 (raw words for the MEM-stage extractors).

Function
REQ-007 The FSM SHALL have three states: IDLE, SECOND and RETURN; RETURN accepts new requests exactly as IDLE does.
REQ-008 In IDLE/RETURN with exactly one effective request, the block SHALL drive that request to the port in the same cycle, keep stallreq=0, and stay in or enter IDLE.
REQ-009 The effective slot-2 request SHALL be req2_valid & ~kill2.
REQ-010 In IDLE/RETURN with both requests effective and not mergeable, the block SHALL drive req1 to the port, set stallreq=1 combinationally, and enter SECOND.
REQ-011 In SECOND, the block SHALL drive req2 to the port with stallreq=0.
REQ-012 In SECOND, data_sram_rdata SHALL be captured into hold1 only while hold_vld=0, and hold_vld SHALL then be set.
REQ-013 SECOND with stall_i=1 SHALL remain in SECOND and re-issue req2 (idempotent); hold1 SHALL NOT be overwritten.
REQ-014 SECOND with stall_i=0 SHALL transition to RETURN.
REQ-015 In RETURN, mem_rdata1 SHALL equal hold1 and mem_rdata2 SHALL equal data_sram_rdata; in every other state, both SHALL equal data_sram_rdata.
REQ-016 hold_vld SHALL clear when RETURN is left with stall_i=0; RETURN with stall_i=1 SHALL hold the state.
REQ-017 A flush in any state SHALL force data_sram_en=0 and data_sram_wen=0 that cycle and enter IDLE next cycle with hold_vld=0; flush takes priority over stall_i.
REQ-018 With no effective request, the block SHALL drive data_sram_en=0 and data_sram_wen=0; addr and wdata are don't-care but SHALL be driven from req1.
REQ-019 data_sram_addr SHALL be passed unmodified; alignment and exceptions are resolved upstream.
REQ-020 kill2 asserted while in SECOND SHALL suppress the port enable for that cycle; the FSM still advances per REQ-013/REQ-014.

Reset
REQ-021 While rst=0, the block SHALL force state=IDLE, hold1=0, hold_vld=0, stallreq=0, data_sram_en=0 and data_sram_wen=0, independent of clk.
REQ-022 Reset asserted mid-SECOND SHALL abandon the slot-2 access with no port enable after assertion.

Configuration
REQ-023 Macro SAME_WORD_MERGE_EN SHALL control same-word access merging.
REQ-024 With SAME_WORD_MERGE_EN defined, two effective requests with equal addr[31:2] that are both loads, or both stores with disjoint wen, SHALL be issued as one access: OR of wen, per-byte wdata taken from the owning slot, stallreq=0, no SECOND.
REQ-025 In the merged case, mem_rdata1 and mem_rdata2 SHALL both equal data_sram_rdata.
REQ-026 Without SAME_WORD_MERGE_EN, every dual request SHALL be serialised per REQ-010 to REQ-016.

Verification
REQ-027 The bench SHALL cover a single load: req1 load 0x100 only -> en=1 same cycle, stallreq=0, mem_rdata1=SRAM[0x100] next cycle.
REQ-028 The bench SHALL cover a dual load: 0x100=0xAAAA5555 and 0x200=0x12345678 -> stallreq=1 for 1 cycle, port addr 0x100 then 0x200, RETURN cycle mem_rdata1=0xAAAA5555 and mem_rdata2=0x12345678.
REQ-029 The bench SHALL cover a store then load: req1 sw 0x300 data 0xDEADBEEF, req2 lw 0x300 -> wen=F then 0, mem_rdata2=0xDEADBEEF.
REQ-030 The bench SHALL cover stall and flush: dual request with stall_i=1 for 3 cycles in SECOND -> req2 re-issued 3+1 times, hold1 unchanged; flush in SECOND -> en=0 that cycle, IDLE next.
REQ-031 The bench SHALL cover kill2: dual request with kill2=1 -> single access to req1_addr, stallreq=0.
REQ-032 The bench SHALL cover merging: with the macro, sb 0x400 wen=0001 plus sb 0x401 wen=0010 -> one access, wen=0011, stallreq=0; without the macro -> two accesses.
